// File: rtl/trans_dispatcher.sv
// trans_dispatcher: round-robin mutex that serialises requester op-codes onto one
// do_work/op_code/work_done transactor handshake, with issue and timeout counters.
module trans_dispatcher #(
  parameter int N_REQ          = 4,
  parameter int OP_W           = 11,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [N_REQ*OP_W-1:0] req_op_code_i,
  output logic [N_REQ-1:0]      req_accept_o,
  output logic [N_REQ-1:0]      req_done_o,
  output logic [N_REQ-1:0]      req_timeout_o,
  output logic                  do_work_o,
  output logic [OP_W-1:0]       op_code_o,
  input  logic                  work_done_i,
  output logic                  busy_o,
  output logic [31:0]           issued_count_o,
  output logic [15:0]           timeout_count_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, COMPLETE} state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q, win_q, win_d;
  logic [TW-1:0]     timer_q;
  logic [OP_W-1:0]   op_q, op_d;
  logic [N_REQ-1:0]  accept_q, done_q, to_q;
  logic              do_work_q, busy_q, found_d;
  logic [31:0]       issued_q;
  logic [15:0]       tcnt_q;
  logic [IW:0]       idx;

  // first requesting slot at or above the pointer, wrapping past N_REQ-1
  always_comb begin
    found_d = 1'b0;
    win_d   = ptr_q;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(i);
      idx = (idx >= (IW+1)'(N_REQ)) ? idx - (IW+1)'(N_REQ) : idx;
      if (!found_d && req_valid_i[idx[IW-1:0]]) begin
        found_d = 1'b1;
        win_d   = idx[IW-1:0];
      end
    end
    op_d = req_op_code_i[int'(win_d)*OP_W +: OP_W];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      timer_q   <= '0;
      op_q      <= '0;
      accept_q  <= '0;
      done_q    <= '0;
      to_q      <= '0;
      do_work_q <= 1'b0;
      busy_q    <= 1'b0;
      issued_q  <= '0;
      tcnt_q    <= '0;
    end else begin
      accept_q  <= '0;
      done_q    <= '0;
      to_q      <= '0;
      do_work_q <= 1'b0;
      case (state_q)
        IDLE: if (found_d) begin
          win_q     <= win_d;
          op_q      <= op_d;
          accept_q  <= N_REQ'(1) << win_d;
          do_work_q <= 1'b1;
          issued_q  <= issued_q + 32'd1;
          timer_q   <= '0;
          busy_q    <= 1'b1;
          state_q   <= WAIT;
        end
        WAIT: if (work_done_i) begin
          done_q  <= N_REQ'(1) << win_q;
          state_q <= COMPLETE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES-1)) begin
          to_q    <= N_REQ'(1) << win_q;
          tcnt_q  <= (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
          state_q <= COMPLETE;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
        COMPLETE: begin
          ptr_q   <= (win_q == IW'(N_REQ-1)) ? '0 : win_q + IW'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_accept_o    = accept_q;
  assign req_done_o      = done_q;
  assign req_timeout_o   = to_q;
  assign do_work_o       = do_work_q;
  assign op_code_o       = op_q;
  assign busy_o          = busy_q;
  assign issued_count_o  = issued_q;
  assign timeout_count_o = tcnt_q;
endmodule
